// File: rtl/load_store_unit.sv
// Load/store unit between the EX/MEM stage and a word-wide data_memory: sub-word loads
// are extracted and extended, sub-word stores use read-modify-write. Option: MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

  localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             r_write;
  logic             r_signed;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic [15:0]      r_wdata;
  logic             trap_hit;

`ifdef MISALIGN_TRAP_EN
  // Half needs addr[0]==0; word (size 1x) needs addr[1:0]==0.
  assign trap_hit = ((req_size == 2'b01) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign trap_hit = 1'b0;
`endif

  // Size 00 = byte, 01 = half, 1x = word; a half always takes lane addr[1].
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] off, input logic [15:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) res[{off, 3'b000} +: 8] = wdata[7:0];
    else               res[{off[1], 4'b0000} +: 16] = wdata;
    return res;
  endfunction

  // NOTE: every register here is state, so it is assigned with <= only; blocking
  // assignments in a clocked block create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= 2'b00;
      r_off         <= 2'b00;
      r_wdata       <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      mem_addr      <= '0;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      mem_writedata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_write   <= req_write;
            r_signed  <= req_signed;
            r_size    <= req_size;
            r_off     <= req_addr[1:0];
            r_wdata   <= req_wdata[15:0];
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            req_ready <= 1'b0;
            cnt       <= CNT_LAST;
            if (trap_hit) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && req_size[1]) begin
              state         <= S_WR;
              MemWrite      <= 1'b1;
              mem_writedata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start with a read.
              state   <= S_RD;
              MemRead <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (cnt == '0) begin
            MemRead <= 1'b0;
            if (r_write) begin
              state         <= S_WR;
              MemWrite      <= 1'b1;
              mem_writedata <= merge(mem_readdata, r_size, r_off, r_wdata);
              cnt           <= CNT_LAST;
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= extract(mem_readdata, r_size, r_signed, r_off);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_WR: begin
          if (cnt == '0) begin
            MemWrite   <= 1'b0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
